// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider. It produces one quotient
// bit per clock.
//
// Operands are accepted on a valid/ready handshake. The result is held on a
// second valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   in_valid       operands on in_dividend/in_divisor are valid
//   in_ready       divider idle (decoded from state only)
//   in_dividend    unsigned dividend
//   in_divisor     unsigned divisor
//   out_valid      quot_out/rem_out/div_zero_out hold a result
//   out_ready      consumer accepts the result
//   quot_out       unsigned quotient (all ones on divide-by-zero)
//   rem_out        unsigned remainder (dividend on divide-by-zero)
//   div_zero_out   result came from a divide-by-zero request
module seq_divider #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot_out,
  output logic [WIDTH-1:0] rem_out,
  output logic             div_zero_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] rem;   // partial remainder
  logic [WIDTH-1:0] quo;   // dividend shifts out the top, quotient bits enter the bottom
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  // The partial remainder stays below the divisor, so trial < 2*divisor.
  // A non-negative difference therefore always fits in WIDTH bits.
  // A negative one leaves trial < divisor, so restoring also fits.
  always_comb begin
    trial = {rem, quo[WIDTH-1]};
    diff  = trial - {1'b0, dvs};
    if (!diff[WIDTH]) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rem          <= '0;
      quo          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      quot_out     <= '0;
      rem_out      <= '0;
      div_zero_out <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_divisor != '0) begin
              quo   <= in_dividend;
              dvs   <= in_divisor;
              rem   <= '0;
              cnt   <= '0;
              state <= CALC;
            end else begin
              quot_out     <= '1;
              rem_out      <= in_dividend;
              div_zero_out <= 1'b1;
              out_valid    <= 1'b1;
              state        <= DONE;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            quot_out     <= quo_nxt;
            rem_out      <= rem_nxt;
            div_zero_out <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
